// File: rtl/calc_display_feeder_if.sv
// Load/start side and OLED-controller side of the calculator display feeder.
// The master drives requests and FIN; the slave is the feeder.
interface calc_display_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic        start;
  logic        busy;
  logic [31:0] opcode_ascii;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        oled_en;
  logic        oled_fin;
  logic        timeout_err;
  logic [7:0]  frame_cnt;

  modport master (
    output in_valid, in_sel, in_data, start, oled_fin,
    input  in_ready, busy, opcode_ascii, operand_a, operand_b, result,
           oled_en, timeout_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_data, start, oled_fin,
    output in_ready, busy, opcode_ascii, operand_a, operand_b, result,
           oled_en, timeout_err, frame_cnt
  );
endinterface

// File: rtl/calc_display_feeder.sv
// Captures A/B/opcode, computes a 32-bit result (shift-add MUL), publishes a
// stable four-word snapshot to the OLED controller and handshakes on FIN.
module calc_display_feeder #(
  parameter int FIN_TIMEOUT = 2000000,
  parameter int TO_W        = 21
) (
  input  logic                 CLK,
  input  logic                 RST,
  calc_display_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COMPUTE, PUBLISH, WAIT_FIN, RELEASE} state_t;
  localparam logic [2:0] OP_MUL = 3'd5;

  state_t state, state_nx;

  logic [31:0]     a_reg, b_reg, snap_a, snap_b, acc;
  logic [2:0]      op_reg, snap_op;
  logic [4:0]      mul_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     pub_ascii, pub_a, pub_b, pub_r;
  logic            en_reg, to_err_reg;
  logic [7:0]      frame_reg;

  logic        load, start_ok, to_hit;
  logic [31:0] a_nx, b_nx;
  logic [2:0]  op_nx;

  function automatic logic [31:0] ascii_of(input logic [2:0] op);
    case (op)
      3'd0:    ascii_of = 32'h41444420;
      3'd1:    ascii_of = 32'h53554220;
      3'd2:    ascii_of = 32'h414E4420;
      3'd3:    ascii_of = 32'h4F522020;
      3'd4:    ascii_of = 32'h584F5220;
      3'd5:    ascii_of = 32'h4D554C20;
      3'd6:    ascii_of = 32'h53484C20;
      default: ascii_of = 32'h53485220;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = a & b;
      3'd3:    alu = a | b;
      3'd4:    alu = a ^ b;
      3'd6:    alu = a << b[4:0];
      3'd7:    alu = a >> b[4:0];
      default: alu = 32'd0;
    endcase
  endfunction

  assign load     = bus.in_valid && (state == IDLE);
  assign start_ok = bus.start && (state == IDLE);
  assign to_hit   = (to_cnt == TO_W'(FIN_TIMEOUT - 1));

  // A load in the start cycle must be visible to the snapshot.
  assign a_nx  = (load && bus.in_sel == 2'd0) ? bus.in_data      : a_reg;
  assign b_nx  = (load && bus.in_sel == 2'd1) ? bus.in_data      : b_reg;
  assign op_nx = (load && bus.in_sel == 2'd2) ? bus.in_data[2:0] : op_reg;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start_ok) state_nx = COMPUTE;
      COMPUTE:  if (snap_op != OP_MUL || mul_cnt == 5'd31) state_nx = PUBLISH;
      PUBLISH:  state_nx = WAIT_FIN;
      WAIT_FIN: begin
        if (bus.oled_fin)  state_nx = RELEASE;
        else if (to_hit)   state_nx = IDLE;
      end
      RELEASE:  if (!bus.oled_fin) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready     = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.opcode_ascii = pub_ascii;
    bus.operand_a    = pub_a;
    bus.operand_b    = pub_b;
    bus.result       = pub_r;
    bus.oled_en      = en_reg;
    bus.timeout_err  = to_err_reg;
    bus.frame_cnt    = frame_reg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg <= '0; b_reg <= '0; op_reg <= '0;
      snap_a <= '0; snap_b <= '0; snap_op <= '0;
      acc <= '0; mul_cnt <= '0; to_cnt <= '0;
      pub_ascii <= '0; pub_a <= '0; pub_b <= '0; pub_r <= '0;
      en_reg <= 1'b0; to_err_reg <= 1'b0; frame_reg <= '0;
    end else begin
      a_reg  <= a_nx;
      b_reg  <= b_nx;
      op_reg <= op_nx;
      case (state)
        IDLE: if (start_ok) begin
          snap_a     <= a_nx;
          snap_b     <= b_nx;
          snap_op    <= op_nx;
          acc        <= '0;
          mul_cnt    <= '0;
          to_err_reg <= 1'b0;
        end
        COMPUTE: begin
          // MUL accumulates one partial product per cycle, bit mul_cnt of B.
          if (snap_op == OP_MUL) begin
            acc     <= acc + (snap_b[mul_cnt] ? (snap_a << mul_cnt) : 32'd0);
            mul_cnt <= mul_cnt + 5'd1;
          end else begin
            acc <= alu(snap_op, snap_a, snap_b);
          end
        end
        PUBLISH: begin
          pub_ascii <= ascii_of(snap_op);
          pub_a     <= snap_a;
          pub_b     <= snap_b;
          pub_r     <= acc;
          en_reg    <= 1'b1;
          to_cnt    <= '0;
        end
        WAIT_FIN: begin
          if (bus.oled_fin) begin
            en_reg    <= 1'b0;
            frame_reg <= frame_reg + 8'd1;
          end else if (to_hit) begin
            en_reg     <= 1'b0;
            to_err_reg <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
